// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the MCU-facing key code, interrupt and debug state.
// master = scanner side, slave = keypad/MCU side.
interface keypad_scanner_if;
  logic       A, C, E;
  logic       B, G, F, D;
  logic [3:0] data;
  logic       interrupt;
  logic [2:0] statePMOD;

  modport master (
    input  A, C, E,
    output B, G, F, D, data, interrupt, statePMOD
  );

  modport slave (
    output A, C, E,
    input  B, G, F, D, data, interrupt, statePMOD
  );
endinterface

// File: rtl/keypad_scanner.sv
// 3x4 keypad scanner: row stepping, whole-scan debounce,
// one latched code and one interrupt pulse per press.
module keypad_scanner #(
  parameter int SCAN_DIV       = 100_000,
  parameter int DEBOUNCE_SCANS = 8,
  parameter int INT_CYCLES     = 8
) (
  input logic              clk,
  input logic              reset,
  keypad_scanner_if.master kp
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int IW = (INT_CYCLES > 2) ? $clog2(INT_CYCLES) : 1;

  localparam logic [4:0] NONE  = 5'h10;
  localparam logic [4:0] MULTI = 5'h11;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    ANNOUNCE = 3'b001,
    HELD     = 3'b010
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      row_q;
  logic [CW-1:0]   div_q;
  logic [2:0]      col_s1, col_s2;
  logic [1:0]      acc_n;
  logic [3:0]      acc_code;
  logic [4:0]      prev_res;
  logic [SW-1:0]   stab_q;
  logic [IW-1:0]   int_cnt;
  logic [3:0]      data_q;
  logic            int_q;
  logic            load, stab_clr;

  logic            dwell_end, scan_end, stable;
  logic [1:0]      row_n, tot_n;
  logic [2:0]      sum;
  logic [3:0]      code_nx;
  logic [4:0]      res;

  function automatic logic [3:0] key_code(
    input logic [1:0] r,
    input logic [2:0] c
  );
    logic [1:0] ci;
    logic [3:0] k;
    ci = c[2] ? 2'd0 : (c[1] ? 2'd1 : 2'd2);
    case (r)
      2'd0:    k = 4'd1 + {2'b0, ci};
      2'd1:    k = 4'd4 + {2'b0, ci};
      2'd2:    k = 4'd7 + {2'b0, ci};
      default: k = (ci == 2'd0) ? 4'hA :
                   (ci == 2'd1) ? 4'h0 : 4'hB;
    endcase
    return k;
  endfunction

  assign dwell_end = div_q == CW'(SCAN_DIV - 1);
  assign scan_end  = dwell_end && (row_q == 2'd3);
  assign stable    = stab_q == SW'(DEBOUNCE_SCANS);

  always_comb begin
    row_n   = {1'b0, col_s2[2]} + {1'b0, col_s2[1]}
            + {1'b0, col_s2[0]};
    sum     = {1'b0, acc_n} + {1'b0, row_n};
    tot_n   = (sum >= 3'd2) ? 2'd2 : sum[1:0];
    code_nx = (row_n == 2'd1) ? key_code(row_q, col_s2)
                              : acc_code;
    res     = (tot_n == 2'd0) ? NONE :
              (tot_n == 2'd1) ? {1'b0, code_nx} : MULTI;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      row_q  <= 2'd0;
      col_s1 <= 3'b0;
      col_s2 <= 3'b0;
    end else begin
      col_s1 <= {kp.C, kp.A, kp.E};
      col_s2 <= col_s1;
      if (dwell_end) begin
        div_q <= '0;
        row_q <= row_q + 2'd1;
      end else begin
        div_q <= div_q + CW'(1);
      end
    end
  end

  // Per-scan accumulation; res folds in the final row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_n    <= 2'd0;
      acc_code <= 4'd0;
      prev_res <= NONE;
      stab_q   <= '0;
    end else begin
      if (dwell_end) begin
        acc_n    <= scan_end ? 2'd0 : tot_n;
        acc_code <= scan_end ? 4'd0 : code_nx;
      end
      if (scan_end)
        prev_res <= res;
      if (stab_clr)
        stab_q <= '0;
      else if (scan_end) begin
        if (res == prev_res && res != MULTI)
          stab_q <= stable ? stab_q : stab_q + SW'(1);
        else
          stab_q <= SW'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    stab_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (stable && !prev_res[4]) begin
          load    = 1'b1;
          state_d = ANNOUNCE;
        end
      end
      ANNOUNCE: begin
        if (int_cnt == IW'(INT_CYCLES - 1))
          state_d = HELD;
      end
      HELD: begin
        if (stable && prev_res == NONE) begin
          stab_clr = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Interrupt trails state by one edge so data is settled first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      int_cnt <= '0;
      data_q  <= 4'hF;
      int_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      int_q   <= state_q == ANNOUNCE;
      int_cnt <= (state_q == ANNOUNCE) ? int_cnt + IW'(1) : '0;
      if (load)
        data_q <= prev_res[3:0];
    end
  end

  assign kp.B         = row_q == 2'd0;
  assign kp.G         = row_q == 2'd1;
  assign kp.F         = row_q == 2'd2;
  assign kp.D         = row_q == 2'd3;
  assign kp.data      = data_q;
  assign kp.interrupt = int_q;
  assign kp.statePMOD = state_q;

endmodule
